// File: rtl/svc_uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and baud divisor helper.
// Pure declarations, no logic; imported by the receiver and the transmitter.
package svc_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_rx_state_t;

    function automatic int uart_clks_per_bit(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/svc_sync_fifo.sv
// Synchronous FIFO, DEPTH (power of two) entries of WIDTH bits, valid/ready on both sides.
// Latency: push-to-m_valid 1 cycle. Backpressure: s_ready low only when full and not popping.
module svc_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full, push, pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign m_valid = (wr_ptr_q != rd_ptr_q);
    assign s_ready = !full || m_ready;
    assign pop     = m_valid && m_ready;
    assign push    = s_valid && s_ready;
    assign m_data  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/svc_uart_rx.sv
// UART 8N1 receiver with start-glitch filter, framing/overrun pulses; buffer is a FIFO under SVC_UART_RX_FIFO_EN, else one holding register.
// Latency: 3 cycles line-to-detect, byte pushed on stop-bit sample, m_valid 1 cycle later. Backpressure: full buffer drops the byte and pulses overrun.
module svc_uart_rx
    import svc_uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       urx,
    output logic       m_valid,
    output logic [7:0] m_data,
    input  logic       m_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CPB   = uart_clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);
    localparam int BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

    uart_rx_state_t            state_q, state_d;
    logic                      sync1_q, sync1_d;
    logic                      sync2_q, sync2_d;
    logic                      prev_q, prev_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [BIT_W-1:0]          bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      push, push_rdy;

    always_comb begin
        sync1_d     = urx;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = cnt_q;
                if (prev_q && !sync2_q) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit is a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = sync2_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {sync2_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    state_d     = IDLE;
                    push        = sync2_q;
                    frame_err_d = !sync2_q;
                end
            end
            default: state_d = IDLE;
        endcase
        overrun_d = push && !push_rdy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

`ifdef SVC_UART_RX_FIFO_EN
    svc_sync_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .s_valid(push),
        .s_ready(push_rdy),
        .s_data (shift_q),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data)
    );
`else
    logic                      hold_vld_q, hold_vld_d;
    logic [UART_DATA_BITS-1:0] hold_dat_q, hold_dat_d;
    logic                      unused_fifo_depth;

    assign unused_fifo_depth = |FIFO_DEPTH;
    // A pop in the same cycle frees the slot for the incoming byte.
    assign push_rdy = !hold_vld_q || m_ready;

    always_comb begin
        hold_vld_d = hold_vld_q && !m_ready;
        hold_dat_d = hold_dat_q;
        if (push && push_rdy) begin
            hold_vld_d = 1'b1;
            hold_dat_d = shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_q <= 1'b0;
            hold_dat_q <= '0;
        end else begin
            hold_vld_q <= hold_vld_d;
            hold_dat_q <= hold_dat_d;
        end
    end

    assign m_valid = hold_vld_q;
    assign m_data  = hold_dat_q;
`endif

endmodule

// File: tb/tb_svc_uart_rx.sv
// Directed bench for svc_uart_rx at CLOCK_FREQ=1000, BAUD_RATE=100 (10 clocks per bit).
// Overrun scenario follows whichever buffer build SVC_UART_RX_FIFO_EN selects.
module tb_svc_uart_rx;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       urx = 1'b1;
    logic       m_ready = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    logic       frame_err;
    logic       overrun;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_start = 0;

    logic [7:0] rx_q[$];
    int         rx_cyc[$];
    int         vld_cycles, fe_cnt, fe_cyc, ov_cnt, ov_cyc;

    svc_uart_rx #(
        .CLOCK_FREQ(1000),
        .BAUD_RATE (100),
        .FIFO_DEPTH(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .urx      (urx),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid) vld_cycles++;
            if (m_valid && m_ready) begin
                rx_q.push_back(m_data);
                rx_cyc.push_back(cyc);
            end
            if (frame_err) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            if (overrun) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
        end
    end

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < rx_cyc.size()) return rx_cyc[i];
        return -1000;
    endfunction

    task automatic clear_mon();
        rx_q.delete();
        rx_cyc.delete();
        vld_cycles = 0;
        fe_cnt     = 0;
        fe_cyc     = -1;
        ov_cnt     = 0;
        ov_cyc     = -1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Frame positions: 0 = start, 1..8 = data LSB first, 9 = stop.
    // rst rises/falls mid-position rst_on/rst_off (-1 = never).
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int rst_on, input int rst_off);
        for (int p = 0; p < 10; p++) begin
            @(posedge clk);
            #1;
            if (p == 0) begin
                urx = 1'b0;
                last_start = cyc;
            end else if (p == 9) begin
                urx = stop_v;
            end else begin
                urx = b[p-1];
            end
            for (int c = 0; c < CPB - 1; c++) begin
                @(posedge clk);
                #1;
                if (p == rst_on && c == 4) rst = 1'b1;
                if (p == rst_off && c == 4) rst = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rst = 1'b0;
        idle(5);
    endtask

    task automatic test_basic();
        clear_mon();
        m_ready = 1'b1;
        send_frame(8'h55, 1'b1, -1, -1);
        idle(20);
        n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", rx_q.size()); end
        n_cmp++; if (rx_at(0) !== 8'h55) begin n_bad++; $display("FAIL basic_data: got %h want 55", rx_at(0)); end
        n_cmp++; if (cyc_at(0) - last_start != 98) begin n_bad++; $display("FAIL basic_latency: got %0d want 98", cyc_at(0) - last_start); end
        n_cmp++; if (vld_cycles != 1) begin n_bad++; $display("FAIL basic_valid_cycles: got %0d want 1", vld_cycles); end
        n_cmp++; if (fe_cnt != 0) begin n_bad++; $display("FAIL basic_frame_err: got %0d want 0", fe_cnt); end
    endtask

    task automatic test_glitch();
        clear_mon();
        m_ready = 1'b1;
        @(posedge clk);
        #1 urx = 1'b0;
        repeat (3) @(posedge clk);
        #1 urx = 1'b1;
        idle(40);
        n_cmp++; if (vld_cycles != 0) begin n_bad++; $display("FAIL glitch_valid: got %0d want 0", vld_cycles); end
        n_cmp++; if (fe_cnt != 0) begin n_bad++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt); end
        send_frame(8'hA3, 1'b1, -1, -1);
        idle(20);
        n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL glitch_next_count: got %0d want 1", rx_q.size()); end
        n_cmp++; if (rx_at(0) !== 8'hA3) begin n_bad++; $display("FAIL glitch_next_data: got %h want a3", rx_at(0)); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        m_ready = 1'b1;
        send_frame(8'h0F, 1'b0, -1, -1);
        idle(30);
        #1 urx = 1'b1;
        idle(20);
        n_cmp++; if (fe_cnt != 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", fe_cnt); end
        n_cmp++; if (fe_cyc - last_start != 98) begin n_bad++; $display("FAIL ferr_timing: got %0d want 98", fe_cyc - last_start); end
        n_cmp++; if (vld_cycles != 0) begin n_bad++; $display("FAIL ferr_valid: got %0d want 0", vld_cycles); end
        send_frame(8'h81, 1'b1, -1, -1);
        idle(20);
        n_cmp++; if (rx_at(0) !== 8'h81) begin n_bad++; $display("FAIL ferr_next_data: got %h want 81", rx_at(0)); end
        n_cmp++; if (fe_cnt != 1) begin n_bad++; $display("FAIL ferr_next_count: got %0d want 1", fe_cnt); end
    endtask

`ifdef SVC_UART_RX_FIFO_EN
    task automatic test_overrun();
        clear_mon();
        m_ready = 1'b0;
        for (int b = 0; b < 17; b++) begin
            send_frame(8'(b), 1'b1, -1, -1);
        end
        idle(20);
        n_cmp++; if (ov_cnt != 1) begin n_bad++; $display("FAIL ovr_count: got %0d want 1", ov_cnt); end
        n_cmp++; if (ov_cyc - last_start != 98) begin n_bad++; $display("FAIL ovr_timing: got %0d want 98", ov_cyc - last_start); end
        @(posedge clk);
        #1 m_ready = 1'b1;
        idle(30);
        n_cmp++; if (rx_q.size() != 16) begin n_bad++; $display("FAIL ovr_drain_count: got %0d want 16", rx_q.size()); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (rx_at(i) !== 8'(i)) begin n_bad++; $display("FAIL ovr_drain_%0d: got %h want %h", i, rx_at(i), 8'(i)); end
        end
        n_cmp++; if (cyc_at(15) - cyc_at(0) != 15) begin n_bad++; $display("FAIL ovr_drain_rate: got %0d want 15", cyc_at(15) - cyc_at(0)); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_valid_after: got %b want 0", m_valid); end
    endtask
`else
    task automatic test_overrun();
        clear_mon();
        m_ready = 1'b0;
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        idle(20);
        #1;
        n_cmp++; if (ov_cnt != 1) begin n_bad++; $display("FAIL ovr_count: got %0d want 1", ov_cnt); end
        n_cmp++; if (ov_cyc - last_start != 98) begin n_bad++; $display("FAIL ovr_timing: got %0d want 98", ov_cyc - last_start); end
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_hold_valid: got %b want 1", m_valid); end
        n_cmp++; if (m_data !== 8'h11) begin n_bad++; $display("FAIL ovr_hold_data: got %h want 11", m_data); end
        @(posedge clk);
        #1 m_ready = 1'b1;
        idle(10);
        n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL ovr_drain_count: got %0d want 1", rx_q.size()); end
        n_cmp++; if (rx_at(0) !== 8'h11) begin n_bad++; $display("FAIL ovr_drain_data: got %h want 11", rx_at(0)); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_valid_after: got %b want 0", m_valid); end
    endtask
`endif

    task automatic test_reset_midframe();
        clear_mon();
        m_ready = 1'b1;
        send_frame(8'hC3, 1'b1, 5, 7);
        idle(20);
        n_cmp++; if (vld_cycles != 0) begin n_bad++; $display("FAIL rstmid_valid: got %0d want 0", vld_cycles); end
        send_frame(8'h5A, 1'b1, -1, -1);
        idle(20);
        n_cmp++; if (rx_q.size() != 1) begin n_bad++; $display("FAIL rstmid_count: got %0d want 1", rx_q.size()); end
        n_cmp++; if (rx_at(0) !== 8'h5A) begin n_bad++; $display("FAIL rstmid_data: got %h want 5a", rx_at(0)); end
        n_cmp++; if (fe_cnt != 0) begin n_bad++; $display("FAIL rstmid_frame_err: got %0d want 0", fe_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
